// File: rtl/score_display_pkg.sv
// Shared constants, converter state encoding and clamp helper for the score overlay.
package score_display_pkg;

    localparam int unsigned GLYPH_W    = 16;
    localparam int unsigned GLYPH_H    = 16;
    localparam int unsigned ROM_ADDR_W = 8;
    localparam int unsigned ROM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    // Largest value representable in n decimal digits (10^n - 1).
    function automatic int unsigned pow10_minus1(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/digit_bitmap.sv
// Digit glyph ROM: 256 x 16, address registered, data valid one cycle later.
// Address = digit*16 + row; bit 15 is the leftmost pixel. Glyphs are drawn as
// thick seven-segment figures; unused addresses read as zero.
module digit_bitmap
    import score_display_pkg::*;
(
    input  logic                  clk,
    input  logic [ROM_ADDR_W-1:0] addr,
    output logic [ROM_DATA_W-1:0] q
);

    logic [ROM_ADDR_W-1:0] addr_q;
    logic [6:0]            seg_c;   // {a,b,c,d,e,f,g}
    logic [3:0]            row_c;

    // Synchronous address capture.
    always_ff @(posedge clk) begin
        addr_q <= addr;
    end

    // Segment set for the addressed digit.
    always_comb begin
        case (addr_q[7:4])
            4'd0:    seg_c = 7'b1111110;
            4'd1:    seg_c = 7'b0110000;
            4'd2:    seg_c = 7'b1101101;
            4'd3:    seg_c = 7'b1111001;
            4'd4:    seg_c = 7'b0110011;
            4'd5:    seg_c = 7'b1011011;
            4'd6:    seg_c = 7'b1011111;
            4'd7:    seg_c = 7'b1110000;
            4'd8:    seg_c = 7'b1111111;
            4'd9:    seg_c = 7'b1111011;
            default: seg_c = 7'b0000000;
        endcase
    end

    // Render one glyph row from the segment set.
    always_comb begin
        row_c = addr_q[3:0];
        q     = '0;
        if (row_c <= 4'd1) begin
            if (seg_c[6]) q = '1;
            if (seg_c[1]) q[15:14] = 2'b11;
            if (seg_c[5]) q[1:0]   = 2'b11;
        end else if (row_c <= 4'd6) begin
            if (seg_c[1]) q[15:14] = 2'b11;
            if (seg_c[5]) q[1:0]   = 2'b11;
        end else if (row_c <= 4'd8) begin
            if (seg_c[0]) q = '1;
            if (seg_c[1]) q[15:14] = 2'b11;
            if (seg_c[5]) q[1:0]   = 2'b11;
        end else if (row_c <= 4'd13) begin
            if (seg_c[2]) q[15:14] = 2'b11;
            if (seg_c[4]) q[1:0]   = 2'b11;
        end else begin
            if (seg_c[3]) q = '1;
            if (seg_c[2]) q[15:14] = 2'b11;
            if (seg_c[4]) q[1:0]   = 2'b11;
        end
    end

endmodule

// File: rtl/score_display_bin_to_bcd.sv
// Sequential double-dabble converter: one add-3/shift step per cycle.
// A load is accepted in IDLE or in the COMMIT cycle (back-to-back operation).
module bin_to_bcd
    import score_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned VAL_W      = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [VAL_W-1:0]        value,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_DIGITS*4-1:0] bcd
);

    localparam int unsigned BCD_W = NUM_DIGITS * 4;
    localparam int unsigned CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

    conv_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [VAL_W-1:0] sr;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] adj_c;

    // Add 3 to every nibble that would exceed 9 after doubling.
    always_comb begin
        adj_c = acc;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (acc[k*4 +: 4] >= 4'd5) begin
                adj_c[k*4 +: 4] = acc[k*4 +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, COMMIT: begin
                    if (load) begin
                        state <= SHIFT;
                        sr    <= value;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    {acc, sr} <= {adj_c, sr} << 1;
                    cnt       <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(VAL_W - 1)) begin
                        state <= COMMIT;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd = acc;

endmodule

// File: rtl/score_display.sv
// Multi-digit numeric overlay: clamps and converts a value to BCD, then
// renders it as adjacent 16x16 glyphs with a 2-cycle pixel pipeline.
module score_display
    import score_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned VAL_W           = 14,
    parameter int unsigned LEAD_ZERO_BLANK = 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [10:0]      iPosX,
    input  logic [10:0]      iPosY,
    input  logic [10:0]      iVGA_X,
    input  logic [10:0]      iVGA_Y,
    input  logic [VAL_W-1:0] iValue,
    input  logic             iLoad,
    input  logic             iEnable,
    output logic             oBusy,
    output logic             oDrawNum
);

    localparam int unsigned COORD_W = 11;
    localparam int unsigned BOX_W   = GLYPH_W * NUM_DIGITS;
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(pow10_minus1(NUM_DIGITS));

    logic                         conv_busy;
    logic                         conv_done;
    logic [NUM_DIGITS*4-1:0]      conv_bcd;
    logic                         pend;
    logic [VAL_W-1:0]             pend_val;
    logic [VAL_W-1:0]             clamp_c;
    logic                         start_c;
    logic [VAL_W-1:0]             start_val_c;
    logic [NUM_DIGITS-1:0][3:0]   disp;
    logic [NUM_DIGITS-1:0]        blank_c;
    logic                         all_zero_c;
    logic [COORD_W-1:0]           dx_c;
    logic [COORD_W-1:0]           dy_c;
    logic                         hit_c;
    logic [IDX_W-1:0]             idx_c;
    logic [3:0]                   nib_c;
    logic                         blank_sel_c;
    logic [ROM_ADDR_W-1:0]        rom_addr_c;
    logic [ROM_DATA_W-1:0]        rom_q;
    logic                         hit_q;
    logic                         en_q;
    logic                         blank_q;
    logic [3:0]                   col_q;

    assign clamp_c = (iValue > MAX_VAL) ? MAX_VAL : iValue;

    // Start a conversion from IDLE, or chain one out of COMMIT; a load in the
    // COMMIT cycle itself is the newest request and wins over the pending one.
    always_comb begin
        start_c     = 1'b0;
        start_val_c = clamp_c;
        if (!conv_busy) begin
            start_c = iLoad;
        end else if (conv_done) begin
            start_c     = iLoad | pend;
            start_val_c = iLoad ? clamp_c : pend_val;
        end
    end

    // Pending request: newest load during SHIFT survives, consumed at COMMIT.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pend     <= 1'b0;
            pend_val <= '0;
        end else if (conv_busy && !conv_done) begin
            if (iLoad) begin
                pend     <= 1'b1;
                pend_val <= clamp_c;
            end
        end else if (conv_done) begin
            pend <= 1'b0;
        end
    end

    bin_to_bcd #(
        .NUM_DIGITS (NUM_DIGITS),
        .VAL_W      (VAL_W)
    ) u_bin_to_bcd (
        .clk   (iClk),
        .rst_n (iRst_n),
        .load  (start_c),
        .value (start_val_c),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign oBusy = conv_busy;

    // Display register only updates with a finished conversion.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            disp <= '0;
        end else if (conv_done) begin
            disp <= conv_bcd;
        end
    end

    // Leading-zero mask derived from the display register; digit 0 always shows.
    always_comb begin
        blank_c    = '0;
        all_zero_c = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero_c = all_zero_c && (disp[i] == 4'd0);
            blank_c[i] = (LEAD_ZERO_BLANK != 0) && all_zero_c;
        end
    end

    // Unsigned offsets: positions left of/above the origin wrap and miss.
    assign dx_c  = iVGA_X - iPosX;
    assign dy_c  = iVGA_Y - iPosY;
    assign hit_c = (dx_c < COORD_W'(BOX_W)) && (dy_c < COORD_W'(GLYPH_H));
    assign idx_c = IDX_W'(NUM_DIGITS - 1) - IDX_W'(dx_c[10:4]);

    // Select the nibble and blank bit of the slot under the scan position.
    always_comb begin
        nib_c       = 4'd0;
        blank_sel_c = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_c == IDX_W'(k)) begin
                nib_c       = disp[k];
                blank_sel_c = blank_c[k];
            end
        end
    end

    assign rom_addr_c = {nib_c, dy_c[3:0]};

    digit_bitmap u_digit_bitmap (
        .clk  (iClk),
        .addr (rom_addr_c),
        .q    (rom_q)
    );

    // Stage 1: carry qualifiers alongside the ROM read.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            hit_q   <= 1'b0;
            en_q    <= 1'b0;
            blank_q <= 1'b0;
            col_q   <= '0;
        end else begin
            hit_q   <= hit_c;
            en_q    <= iEnable;
            blank_q <= blank_sel_c;
            col_q   <= dx_c[3:0];
        end
    end

    // Stage 2: registered pixel-on flag.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oDrawNum <= 1'b0;
        end else begin
            oDrawNum <= hit_q & en_q & ~blank_q & rom_q[4'(ROM_DATA_W - 1) - col_q];
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: two instances (blanking on/off) share stimulus.
module tb_score_display;

    localparam int unsigned VAL_W = 14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [10:0]      pos_x, pos_y, vga_x, vga_y;
    logic [VAL_W-1:0] value;
    logic             load, enable;
    logic             busy_b, draw_b, busy_n, draw_n;

    int checks = 0;
    int errors = 0;
    int cur_val = 0;
    int n;

    // Hand-drawn reference rows (bit 15 = leftmost) for rows 0, 4 and 10.
    logic [15:0] g_row0  [10] = '{16'hFFFF, 16'h0003, 16'hFFFF, 16'hFFFF, 16'hC003,
                                  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic [15:0] g_row4  [10] = '{16'hC003, 16'h0003, 16'h0003, 16'h0003, 16'hC003,
                                  16'hC000, 16'hC000, 16'h0003, 16'hC003, 16'hC003};
    logic [15:0] g_row10 [10] = '{16'hC003, 16'h0003, 16'hC000, 16'h0003, 16'h0003,
                                  16'h0003, 16'hC003, 16'h0003, 16'hC003, 16'h0003};

    always #5 clk = ~clk;

    score_display #(.NUM_DIGITS(4), .VAL_W(VAL_W), .LEAD_ZERO_BLANK(1)) dut (
        .iClk(clk), .iRst_n(rst_n), .iPosX(pos_x), .iPosY(pos_y),
        .iVGA_X(vga_x), .iVGA_Y(vga_y), .iValue(value), .iLoad(load),
        .iEnable(enable), .oBusy(busy_b), .oDrawNum(draw_b)
    );

    score_display #(.NUM_DIGITS(4), .VAL_W(VAL_W), .LEAD_ZERO_BLANK(0)) dut_nb (
        .iClk(clk), .iRst_n(rst_n), .iPosX(pos_x), .iPosY(pos_y),
        .iVGA_X(vga_x), .iVGA_Y(vga_y), .iValue(value), .iLoad(load),
        .iEnable(enable), .oBusy(busy_n), .oDrawNum(draw_n)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected pixel for a 4-digit display at origin (100,50).
    function automatic int exp_pix(input int x, input int y, input int val, input bit lzb);
        int dx, dy, k, p, d;
        logic [15:0] r;
        dx = x - 100;
        dy = y - 50;
        if (dx < 0 || dx >= 64 || dy < 0 || dy >= 16) return 0;
        k = 3 - dx / 16;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        d = (val / p) % 10;
        if (lzb && k != 0 && val < p) return 0;
        case (dy)
            0:       r = g_row0[d];
            4:       r = g_row4[d];
            10:      r = g_row10[d];
            default: r = '0;
        endcase
        return int'(r[15 - (dx % 16)]);
    endfunction

    // Stream x=96..167 on one line, comparing each pixel two cycles later.
    task automatic scan_row(input int y);
        int x;
        for (int i = 0; i < 74; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                x = 96 + i - 2;
                check($sformatf("lzb1 val%0d x%0d y%0d", cur_val, x, y),
                      int'(draw_b), exp_pix(x, y, cur_val, 1'b1));
                check($sformatf("lzb0 val%0d x%0d y%0d", cur_val, x, y),
                      int'(draw_n), exp_pix(x, y, cur_val, 1'b0));
            end
            if (i < 72) begin
                vga_x = 11'(96 + i);
                vga_y = 11'(y);
            end
        end
    endtask

    task automatic load_val(input int v);
        @(negedge clk);
        value = VAL_W'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy_b && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        pos_x  = 11'd100;
        pos_y  = 11'd50;
        vga_x  = '0;
        vga_y  = '0;
        value  = '0;
        load   = 1'b0;
        enable = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy_b), 0);
        check("rst_draw", int'(draw_b), 0);
        rst_n = 1'b1;

        // Reset display: "0" in digit-0 slot only (blanking on), "0000" otherwise.
        cur_val = 0;
        scan_row(50);
        scan_row(54);
        check("idle_busy", int'(busy_b), 0);

        load_val(1234);
        check("busy_rise", int'(busy_b), 1);
        wait_idle(n);
        check("busy_len_1234", n, 15);
        cur_val = 1234;
        scan_row(50);
        scan_row(54);
        scan_row(60);

        load_val(7);
        wait_idle(n);
        check("busy_len_7", n, 15);
        cur_val = 7;
        scan_row(50);
        scan_row(54);
        scan_row(60);

        // Clamp to all nines.
        load_val(12000);
        wait_idle(n);
        check("busy_len_clamp", n, 15);
        cur_val = 9999;
        scan_row(50);
        scan_row(54);
        scan_row(49);
        scan_row(66);

        // Exact 2-cycle latency and enable alignment at the origin pixel.
        @(negedge clk);
        vga_x = 11'd99;
        vga_y = 11'd50;
        @(negedge clk);
        @(negedge clk);
        check("lat_pre", int'(draw_b), 0);
        vga_x = 11'd100;
        @(negedge clk);
        check("lat_1cyc", int'(draw_b), 0);
        @(negedge clk);
        check("lat_2cyc", int'(draw_b), 1);
        enable = 1'b0;
        @(negedge clk);
        check("en_1cyc", int'(draw_b), 1);
        @(negedge clk);
        check("en_2cyc", int'(draw_b), 0);
        enable = 1'b1;

        // Two loads during a conversion: only the newest (9) is converted next.
        load_val(12000);
        load_val(3);
        load_val(9);
        wait_idle(n);
        check("busy_len_pending", n, 26);
        cur_val = 9;
        scan_row(50);
        scan_row(54);
        scan_row(60);

        // Reset mid-conversion with a pending load queued.
        load_val(1234);
        load_val(5678);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy_b", int'(busy_b), 0);
        check("rst_mid_busy_n", int'(busy_n), 0);
        check("rst_mid_draw", int'(draw_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_b) n++;
        end
        check("rst_no_pending", n, 0);
        cur_val = 0;
        scan_row(50);
        scan_row(54);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
